// File: rtl/pwm_gen_mc_if.sv
// Configuration/status bundle for the multi-channel PWM engine.
// master = register block side, slave = PWM engine.
interface pwm_gen_mc_if #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8
);
  logic                      pwm_en;
  logic [CNT_W-1:0]          cfg_period;
  logic [PRESC_W-1:0]        cfg_prescale;
  logic [2*NUM_CH-1:0]       cfg_functions;
  logic [CNT_W*NUM_CH-1:0]   cfg_compare1;
  logic [CNT_W*NUM_CH-1:0]   cfg_compare2;
  logic [NUM_CH-1:0]         cfg_polarity;
  logic                      cfg_update;
  logic [CNT_W-1:0]          count_val;
  logic [NUM_CH-1:0]         pwm_out;
  logic                      period_tick;
  logic                      update_pending;

  modport master (
    output pwm_en, cfg_period, cfg_prescale, cfg_functions, cfg_compare1,
           cfg_compare2, cfg_polarity, cfg_update,
    input  count_val, pwm_out, period_tick, update_pending
  );

  modport slave (
    input  pwm_en, cfg_period, cfg_prescale, cfg_functions, cfg_compare1,
           cfg_compare2, cfg_polarity, cfg_update,
    output count_val, pwm_out, period_tick, update_pending
  );
endinterface

// File: rtl/pwm_gen_mc.sv
// Multi-channel PWM engine: shared prescaled timebase, per-channel mode/compare/polarity,
// double-buffered configuration loaded only at period boundaries.

module pwm_gen_mc_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic [1:0]       func,
  input  logic [CNT_W-1:0] cmp1,
  input  logic [CNT_W-1:0] cmp2,
  input  logic             pol,
  output logic             pwm
);
  logic raw;

  always_comb begin
    raw = 1'b0;
    case (func)
      2'b00:   raw = (cnt < cmp1);
      2'b01:   raw = (cnt >= cmp1);
      // an empty or inverted window naturally yields 0
      2'b10:   raw = (cnt >= cmp1) && (cnt < cmp2);
      default: raw = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pwm <= 1'b0;
    else        pwm <= en ? (raw ^ pol) : pol;
endmodule

module pwm_gen_mc #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  pwm_gen_mc_if.slave bus
);
  logic [PRESC_W-1:0]           presc_q;
  logic [CNT_W-1:0]             cnt_q;
  logic                         tick_q;
  logic                         pend_q;
  logic [NUM_CH-1:0]            pwm_q;

  logic [CNT_W-1:0]             act_period;
  logic [PRESC_W-1:0]           act_presc;
  logic [NUM_CH-1:0][1:0]       act_func;
  logic [NUM_CH-1:0][CNT_W-1:0] act_cmp1;
  logic [NUM_CH-1:0][CNT_W-1:0] act_cmp2;
  logic [NUM_CH-1:0]            act_pol;

  logic             tick, wrap, load, cfg_copy;
  logic [CNT_W-1:0] period_m1;

  assign tick      = bus.pwm_en && (presc_q == act_presc);
  // period 0 behaves as period 1; >= also recovers any count beyond the last tick
  assign period_m1 = (act_period == '0) ? '0 : act_period - CNT_W'(1);
  assign wrap      = tick && (cnt_q >= period_m1);
  assign load      = wrap && (pend_q || bus.cfg_update);
  assign cfg_copy  = !bus.pwm_en || load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else if (!bus.pwm_en) begin
      presc_q <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
      if (wrap)      cnt_q <= '0;
      else if (tick) cnt_q <= cnt_q + CNT_W'(1);
      tick_q  <= wrap;
      pend_q  <= load ? 1'b0 : (pend_q || bus.cfg_update);
    end
  end

  // shadow -> active: transparent while disabled, otherwise only at a boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_period <= '0;
      act_presc  <= '0;
      act_func   <= '0;
      act_cmp1   <= '0;
      act_cmp2   <= '0;
      act_pol    <= '0;
    end else if (cfg_copy) begin
      act_period <= bus.cfg_period;
      act_presc  <= bus.cfg_prescale;
      act_func   <= bus.cfg_functions;
      act_cmp1   <= bus.cfg_compare1;
      act_cmp2   <= bus.cfg_compare2;
      act_pol    <= bus.cfg_polarity;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_gen_mc_ch #(.CNT_W(CNT_W)) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (bus.pwm_en),
      .cnt  (cnt_q),
      .func (act_func[i]),
      .cmp1 (act_cmp1[i]),
      .cmp2 (act_cmp2[i]),
      .pol  (act_pol[i]),
      .pwm  (pwm_q[i])
    );
  end

  assign bus.count_val      = cnt_q;
  assign bus.pwm_out        = pwm_q;
  assign bus.period_tick    = tick_q;
  assign bus.update_pending = pend_q;
endmodule

// File: tb/tb_pwm_gen_mc.sv
// Scoreboard bench for pwm_gen_mc: closed-form expectations queued per scenario,
// popped and compared one clk at a time, #1 after the rising edge.
module tb_pwm_gen_mc;
  localparam int NCH = 4, CW = 16, PW = 8;

  typedef struct packed {
    logic [CW-1:0]  cnt;
    logic [NCH-1:0] pwm;
    logic           tick;
    logic           pend;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pwm_gen_mc_if #(.NUM_CH(NCH), .CNT_W(CW), .PRESC_W(PW)) bus ();

  pwm_gen_mc #(.NUM_CH(NCH), .CNT_W(CW), .PRESC_W(PW)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic set_ch(input int i, input logic [1:0] m, input logic [CW-1:0] c1,
                        input logic [CW-1:0] c2);
    bus.cfg_functions[2*i +: 2]  = m;
    bus.cfg_compare1[CW*i +: CW] = c1;
    bus.cfg_compare2[CW*i +: CW] = c2;
  endtask

  task automatic idle(input int n);
    bus.pwm_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic exp_t obs();
    exp_t o;
    o = {bus.count_val, bus.pwm_out, bus.period_tick, bus.update_pending};
    return o;
  endfunction

  task automatic test_reset();
    exp_t e, o;
    rst_n = 1'b0;
    bus.pwm_en = 1'b1; bus.cfg_update = 1'b0;
    bus.cfg_period = 16'd10; bus.cfg_prescale = '0; bus.cfg_polarity = 4'b1111;
    for (int i = 0; i < NCH; i++) set_ch(i, 2'b00, 16'd3, 16'd0);
    for (int k = 0; k < 2; k++) sb.push_back('0);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) #3; else begin @(posedge clk); #1; end
      o = obs(); e = sb.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset k=%0d got cnt=%0d pwm=%b tick=%b pend=%b exp cnt=%0d pwm=%b tick=%b pend=%b",
                 k, o.cnt, o.pwm, o.tick, o.pend, e.cnt, e.pwm, e.tick, e.pend);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_modes();
    exp_t e, o;
    bus.cfg_period = 16'd10; bus.cfg_prescale = '0; bus.cfg_polarity = 4'b1000;
    set_ch(0, 2'b00, 16'd3, 16'd0); set_ch(1, 2'b01, 16'd3, 16'd0);
    set_ch(2, 2'b10, 16'd2, 16'd6); set_ch(3, 2'b11, 16'd0, 16'd0);
    idle(2);
    // disabled: outputs sit at the polarity level, count 0
    sb.push_back({16'd0, 4'b1000, 1'b0, 1'b0});
    o = obs(); e = sb.pop_front(); tests++;
    if (o !== e) begin
      fails++;
      $display("FAIL modes_idle got cnt=%0d pwm=%b tick=%b pend=%b exp cnt=%0d pwm=%b tick=%b pend=%b",
               o.cnt, o.pwm, o.tick, o.pend, e.cnt, e.pwm, e.tick, e.pend);
    end
    for (int k = 0; k < 25; k++) begin
      int c = k % 10;
      e.cnt  = 16'((k + 1) % 10);
      e.pwm  = {1'b1, (c >= 2 && c < 6), c >= 3, c < 3};
      e.tick = ((k + 1) % 10 == 0);
      e.pend = 1'b0;
      sb.push_back(e);
    end
    bus.pwm_en = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      o = obs(); e = sb.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL modes k=%0d got cnt=%0d pwm=%b tick=%b pend=%b exp cnt=%0d pwm=%b tick=%b pend=%b",
                 k, o.cnt, o.pwm, o.tick, o.pend, e.cnt, e.pwm, e.tick, e.pend);
      end
    end
  endtask

  task automatic test_prescale();
    exp_t e, o;
    bus.cfg_period = 16'd4; bus.cfg_prescale = 8'd2; bus.cfg_polarity = '0;
    set_ch(0, 2'b00, 16'd2, 16'd0);
    for (int i = 1; i < NCH; i++) set_ch(i, 2'b11, 16'd0, 16'd0);
    idle(2);
    for (int k = 0; k < 30; k++) begin
      e.cnt  = 16'(((k + 1) / 3) % 4);
      e.pwm  = {3'b000, ((k / 3) % 4) < 2};
      e.tick = (k % 12 == 11);
      e.pend = 1'b0;
      sb.push_back(e);
    end
    bus.pwm_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      o = obs(); e = sb.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL prescale k=%0d got cnt=%0d pwm=%b tick=%b pend=%b exp cnt=%0d pwm=%b tick=%b pend=%b",
                 k, o.cnt, o.pwm, o.tick, o.pend, e.cnt, e.pwm, e.tick, e.pend);
      end
    end
  endtask

  task automatic test_update();
    exp_t e, o;
    bus.cfg_period = 16'd10; bus.cfg_prescale = '0; bus.cfg_polarity = '0;
    set_ch(0, 2'b00, 16'd3, 16'd0);
    for (int i = 1; i < NCH; i++) set_ch(i, 2'b11, 16'd0, 16'd0);
    idle(2);
    for (int k = 0; k < 35; k++) begin
      e.cnt  = 16'((k + 1) % 10);
      e.pwm  = {3'b000, (k % 10) < (k >= 20 ? 7 : 3)};
      e.tick = ((k + 1) % 10 == 0);
      e.pend = (k >= 15 && k <= 18);
      sb.push_back(e);
    end
    bus.pwm_en = 1'b1;
    for (int k = 0; k < 35; k++) begin
      @(posedge clk); #1;
      o = obs(); e = sb.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL update k=%0d got cnt=%0d pwm=%b tick=%b pend=%b exp cnt=%0d pwm=%b tick=%b pend=%b",
                 k, o.cnt, o.pwm, o.tick, o.pend, e.cnt, e.pwm, e.tick, e.pend);
      end
      if (k == 4)  set_ch(0, 2'b00, 16'd7, 16'd0);
      if (k == 14 || k == 16) bus.cfg_update = 1'b1;
      if (k == 15 || k == 17) bus.cfg_update = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    bus.cfg_period = 16'd10; bus.cfg_prescale = '0; bus.cfg_polarity = '0;
    set_ch(0, 2'b00, 16'd3, 16'd0);
    for (int i = 1; i < NCH; i++) set_ch(i, 2'b11, 16'd0, 16'd0);
    idle(2);
    // update lands in the wrap clk itself: period 4 from the very next count 0
    for (int k = 0; k < 26; k++) begin
      int prev = (k <= 9) ? k : (k - 10) % 4;
      e.cnt  = (k <= 8) ? 16'(k + 1) : 16'((k - 9) % 4);
      e.pwm  = {3'b000, prev < 3};
      e.tick = (k >= 9) && ((k - 9) % 4 == 0);
      e.pend = 1'b0;
      sb.push_back(e);
    end
    bus.pwm_en = 1'b1;
    for (int k = 0; k < 26; k++) begin
      @(posedge clk); #1;
      o = obs(); e = sb.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL coincident_update k=%0d got cnt=%0d pwm=%b tick=%b pend=%b exp cnt=%0d pwm=%b tick=%b pend=%b",
                 k, o.cnt, o.pwm, o.tick, o.pend, e.cnt, e.pwm, e.tick, e.pend);
      end
      if (k == 7) bus.cfg_period = 16'd4;
      if (k == 8) bus.cfg_update = 1'b1;
      if (k == 9) bus.cfg_update = 1'b0;
    end
  endtask

  task automatic test_edge_duty();
    exp_t e, o;
    bus.cfg_period = 16'd10; bus.cfg_prescale = '0; bus.cfg_polarity = '0;
    set_ch(0, 2'b00, 16'd0,  16'd0);
    set_ch(1, 2'b00, 16'd10, 16'd0);
    set_ch(2, 2'b01, 16'd0,  16'd0);
    set_ch(3, 2'b10, 16'd5,  16'd5);
    idle(2);
    for (int k = 0; k < 22; k++) begin
      e.cnt  = 16'((k + 1) % 10);
      e.pwm  = 4'b0110;
      e.tick = ((k + 1) % 10 == 0);
      e.pend = 1'b0;
      sb.push_back(e);
    end
    bus.pwm_en = 1'b1;
    for (int k = 0; k < 22; k++) begin
      @(posedge clk); #1;
      o = obs(); e = sb.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL edge_duty k=%0d got cnt=%0d pwm=%b tick=%b pend=%b exp cnt=%0d pwm=%b tick=%b pend=%b",
                 k, o.cnt, o.pwm, o.tick, o.pend, e.cnt, e.pwm, e.tick, e.pend);
      end
    end
  endtask

  task automatic test_period_zero();
    exp_t e, o;
    bus.cfg_period = 16'd0; bus.cfg_prescale = 8'd1; bus.cfg_polarity = '0;
    set_ch(0, 2'b00, 16'd1, 16'd0);
    for (int i = 1; i < NCH; i++) set_ch(i, 2'b11, 16'd0, 16'd0);
    idle(2);
    for (int k = 0; k < 10; k++) begin
      e.cnt  = 16'd0;
      e.pwm  = 4'b0001;
      e.tick = (k % 2 == 1);
      e.pend = 1'b0;
      sb.push_back(e);
    end
    bus.pwm_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      o = obs(); e = sb.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL period_zero k=%0d got cnt=%0d pwm=%b tick=%b pend=%b exp cnt=%0d pwm=%b tick=%b pend=%b",
                 k, o.cnt, o.pwm, o.tick, o.pend, e.cnt, e.pwm, e.tick, e.pend);
      end
    end
  endtask

  task automatic test_disable();
    exp_t e, o;
    bus.cfg_period = 16'd10; bus.cfg_prescale = '0; bus.cfg_polarity = 4'b1010;
    set_ch(0, 2'b00, 16'd3, 16'd0); set_ch(1, 2'b01, 16'd3, 16'd0);
    set_ch(2, 2'b11, 16'd0, 16'd0); set_ch(3, 2'b11, 16'd0, 16'd0);
    idle(2);
    for (int k = 0; k < 10; k++) begin
      e.cnt  = (k < 6) ? 16'(k + 1) : 16'd0;
      e.pwm  = (k < 6) ? {2'b10, k < 3, k < 3} : 4'b1010;
      e.tick = 1'b0;
      e.pend = (k == 4 || k == 5);
      sb.push_back(e);
    end
    bus.pwm_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      o = obs(); e = sb.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL disable k=%0d got cnt=%0d pwm=%b tick=%b pend=%b exp cnt=%0d pwm=%b tick=%b pend=%b",
                 k, o.cnt, o.pwm, o.tick, o.pend, e.cnt, e.pwm, e.tick, e.pend);
      end
      if (k == 3) bus.cfg_update = 1'b1;
      if (k == 4) bus.cfg_update = 1'b0;
      if (k == 5) bus.pwm_en = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, o;
    bus.cfg_period = 16'd10; bus.cfg_prescale = '0; bus.cfg_polarity = 4'b1111;
    set_ch(0, 2'b00, 16'd3, 16'd0);
    for (int i = 1; i < NCH; i++) set_ch(i, 2'b11, 16'd0, 16'd0);
    idle(2);
    for (int k = 0; k < 5; k++) begin
      e.cnt  = 16'(k + 1);
      e.pwm  = {3'b111, !(k < 3)};
      e.tick = 1'b0;
      e.pend = 1'b0;
      sb.push_back(e);
    end
    sb.push_back('0);
    bus.pwm_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) begin @(posedge clk); #1; end
      else begin #2 rst_n = 1'b0; #1; end
      o = obs(); e = sb.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset_mid k=%0d got cnt=%0d pwm=%b tick=%b pend=%b exp cnt=%0d pwm=%b tick=%b pend=%b",
                 k, o.cnt, o.pwm, o.tick, o.pend, e.cnt, e.pwm, e.tick, e.pend);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_modes();
    test_prescale();
    test_update();
    test_back_to_back();
    test_edge_duty();
    test_period_zero();
    test_disable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
